// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_rdcache.sv
// One-entry read cache: word tag + data with a combinational hit compare.
// Only instantiated when DMEM_RDCACHE_EN is defined.
module dmem_rdcache
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       i_lookup_tag,
  output logic              o_hit,
  output logic [WORD_W-1:0] o_data,
  input  logic              i_fill,
  input  logic              i_wr_upd,
  input  logic [29:0]       i_upd_tag,
  input  logic [WORD_W-1:0] i_upd_data,
  input  logic              i_inval
);

  logic              r_valid;
  logic [29:0]       r_tag;
  logic [WORD_W-1:0] r_data;

  assign o_hit  = r_valid & (r_tag == i_lookup_tag);
  assign o_data = r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_upd_tag;
      r_data  <= i_upd_data;
    end else if (i_wr_upd && r_valid && (r_tag == i_upd_tag)) begin
      // Keep the entry coherent with stores to the cached word.
      r_data <= i_upd_data;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns core loads/stores into req/ack bus
// transactions and stalls the core meanwhile. Optional read cache: DMEM_RDCACHE_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter int                TO_W     = 5,
  parameter logic [WORD_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] readdata,
  output logic              stall,
  output logic              misalign,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [WORD_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  state_t            r_state;
  state_t            w_state_next;
  logic [TO_W-1:0]   r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [WORD_W-1:0] r_bus_addr;
  logic [WORD_W-1:0] r_bus_wdata;
  logic [WORD_W-1:0] r_readdata;
  logic              r_err;
  logic              r_misalign;

  logic w_access;
  logic w_aligned;
  logic w_hit;
  logic w_launch;
  logic w_misal;
  logic w_ack_ok;
  logic w_abort;

  assign w_access  = memread | memwrite;
  assign w_aligned = (addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_misal      = 1'b0;
    w_ack_ok     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access && !w_hit) begin
          if (w_aligned) begin
            w_launch     = 1'b1;
            w_state_next = ST_REQ;
          end else begin
            w_misal = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // A late ack on the final counted cycle still wins over the abort.
        if (bus_ack) begin
          w_ack_ok     = 1'b1;
          w_state_next = ST_DONE;
        end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
          w_abort      = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_readdata  <= '0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= w_misal;
      if (w_launch) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= memwrite;
        r_bus_addr  <= {addr[WORD_W-1:2], 2'b00};
        r_bus_wdata <= wdata;
        r_cnt       <= '0;
      end
      if (w_misal) r_readdata <= '0;
      if (w_ack_ok) begin
        r_bus_req <= 1'b0;
        if (!r_bus_we) r_readdata <= bus_rdata;
      end
      if (w_abort) begin
        r_bus_req <= 1'b0;
        r_err     <= 1'b1;
        if (!r_bus_we) r_readdata <= ERR_DATA;
      end
      if (r_state == ST_REQ && !bus_ack && !w_abort) r_cnt <= r_cnt + TO_W'(1);
      if (r_state == ST_DONE) r_cnt <= '0;
    end
  end

`ifdef DMEM_RDCACHE_EN
  logic              w_cache_hit;
  logic [WORD_W-1:0] w_cache_data;

  dmem_rdcache u_rdcache (
    .clk          (clk),
    .reset        (reset),
    .i_lookup_tag (addr[WORD_W-1:2]),
    .o_hit        (w_cache_hit),
    .o_data       (w_cache_data),
    .i_fill       (w_ack_ok & ~r_bus_we),
    .i_wr_upd     (w_ack_ok & r_bus_we),
    .i_upd_tag    (r_bus_addr[WORD_W-1:2]),
    .i_upd_data   (r_bus_we ? r_bus_wdata : bus_rdata),
    .i_inval      (w_abort | w_misal)
  );

  assign w_hit    = memread & ~memwrite & w_aligned & (r_state == ST_IDLE) & w_cache_hit;
  assign readdata = w_hit ? w_cache_data : r_readdata;
`else
  assign w_hit    = 1'b0;
  assign readdata = r_readdata;
`endif

  assign stall     = w_access & w_aligned & (r_state != ST_DONE) & ~w_hit;
  assign misalign  = r_misalign;
  assign err       = r_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a transaction-level model
// (word memory, sticky error, one-entry cache when DMEM_RDCACHE_EN is defined).
module tb_dmem_ctrl;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
`ifdef DMEM_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] readdata;
  logic        stall, misalign, err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_txn     = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_rd  = '0;
  logic        exp_err = 1'b0;
  logic        c_valid = 1'b0;
  logic [29:0] c_tag   = '0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .readdata(readdata), .stall(stall),
    .misalign(misalign), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_asserts++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic clear_inputs();
    memread  = 1'b0;
    memwrite = 1'b0;
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // Called at posedge+1; returns at posedge+1. dly = REQ cycles before ack (>=16: never).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int dly);
    int          idx, st, rq, exp_req, exp_stall;
    bit          hit, tmo, done;
    logic [31:0] want_rd;
    idx = int'(a[9:2]);
    n_txn++;
    memread = rd; memwrite = wr; addr = a; wdata = wd;
    if (a[1:0] != 2'b00) begin
      @(negedge clk);
      check("mis_stall", 32'(stall), 32'd0);
      check("mis_noreq0", 32'(bus_req), 32'd0);
      check("mis_pre", 32'(misalign), 32'd0);
      @(posedge clk); #1 clear_inputs();
      @(negedge clk);
      check("mis_pulse", 32'(misalign), 32'd1);
      check("mis_rd", readdata, 32'd0);
      check("mis_noreq1", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_end", 32'(misalign), 32'd0);
      @(posedge clk); #1;
      exp_rd  = '0;
      c_valid = 1'b0;
      $display("txn %0d: misaligned addr=%h", n_txn, a);
      return;
    end
    hit = CACHE && c_valid && (c_tag == a[31:2]) && rd && !wr;
    tmo = !hit && (dly >= 16);
    exp_req   = hit ? 0 : (tmo ? 16 : dly + 1);
    exp_stall = hit ? 0 : exp_req + 1;
    if (hit)          want_rd = mem[idx];
    else if (wr)      want_rd = exp_rd;
    else if (tmo)     want_rd = ERR_WORD;
    else              want_rd = mem[idx];
    st = 0; rq = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0 && !hit) check("rd_hold", readdata, exp_rd);
      if (stall) begin
        st++;
        if (bus_req) begin
          rq++;
          check("bus_addr", bus_addr, {a[31:2], 2'b00});
          check("bus_we", 32'(bus_we), 32'(wr));
          check("bus_wdata", bus_wdata, wd);
          if (rq == dly + 1) begin
            bus_ack   = 1'b1;
            bus_rdata = mem[idx];
          end
        end
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end else begin
        done = 1;
      end
    end
    if (!done) check("cycle_bound", 32'd0, 32'd1);
    if (tmo) exp_err = 1'b1;
    check("stall_cycles", 32'(st), 32'(exp_stall));
    check("req_cycles", 32'(rq), 32'(exp_req));
    check("readdata", readdata, want_rd);
    check("err", 32'(err), 32'(exp_err));
    check("req_low", 32'(bus_req), 32'd0);
    check("no_misalign", 32'(misalign), 32'd0);
    @(posedge clk); #1 clear_inputs();
    if (!hit) begin
      if (!wr) exp_rd = want_rd;
      if (tmo) c_valid = 1'b0;
      else if (wr) mem[idx] = wd;
      else begin c_valid = 1'b1; c_tag = a[31:2]; end
    end
    $display("txn %0d: rd=%0b wr=%0b addr=%h dly=%0d hit=%0b stall=%0d req=%0d readdata=%h",
             n_txn, rd, wr, a, dly, hit, st, rq, readdata);
  endtask

  task automatic idle_gap();
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(negedge clk);
    check("idle_rd", readdata, exp_rd);
    check("idle_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    int k, r, dly;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    mem[8'h40] = 32'h12345678;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 0);
    do_access(1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 2);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 99);
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 0);

    // Reset during REQ, then a stray ack that must be ignored.
    memread = 1'b1; addr = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_req", 32'(bus_req), 32'd1);
    reset = 1'b0; memread = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rstmid_req0", 32'(bus_req), 32'd0);
    check("rstmid_err", 32'(err), 32'd0);
    check("rstmid_stall", 32'(stall), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h5A5A1234;
    @(posedge clk); #1 bus_ack = 1'b0;
    @(negedge clk);
    check("rstmid_rd", readdata, 32'd0);
    check("rstmid_noreq", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    exp_rd = '0; exp_err = 1'b0; c_valid = 1'b0;
    $display("txn: reset during REQ");

    mem[8'h40] = 32'hA5A5A5A5;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 1);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 2);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 15);

    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 6)      dly = r % 4;
      else if (r < 8) dly = 15;
      else if (r < 9) dly = 16 + $urandom_range(0, 4);
      else            dly = 5;
      a = {22'd0, 4'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_access(k < 2 || k == 3, k >= 2, a, $urandom, dly);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
